// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: pipeline-wide entry record, default sizes and pointer-width helper
package instruction_queue_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 32;
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] instruction;
    logic [DEFAULT_WIDTH-1:0] pc_add_result;
  } entry_t;
  function automatic int ptr_w(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch/decode/redirect signals between the pipeline stages and the queue
interface instruction_queue_if
  import instruction_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  logic [WIDTH-1:0] Instruction;
  logic [WIDTH-1:0] PCAddResult;
  logic InValid;
  logic InReady;
  logic [WIDTH-1:0] OutInstruction;
  logic [WIDTH-1:0] OutPCAddResult;
  logic OutValid;
  logic OutReady;
  logic RedirectValid;
  logic [WIDTH-1:0] RedirectAddress;
  logic Branch;
  logic [WIDTH-1:0] BranchAddress;
  logic [ptr_w(DEPTH):0] Count;
  modport master (
    output Instruction, PCAddResult, InValid, OutReady, RedirectValid, RedirectAddress,
    input InReady, OutInstruction, OutPCAddResult, OutValid, Branch, BranchAddress, Count
  );
  modport slave (
    input Instruction, PCAddResult, InValid, OutReady, RedirectValid, RedirectAddress,
    output InReady, OutInstruction, OutPCAddResult, OutValid, Branch, BranchAddress, Count
  );
endinterface

// File: rtl/queue_storage.sv
// queue_storage: register file with one write port and one asynchronous read port
module queue_storage #(
  parameter int DEPTH = 4,
  parameter int DW = 64,
  parameter int AW = 2
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: fetch-to-decode FIFO with redirect flush and one-cycle fetch squash
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic Clk,
  input logic Reset,
  instruction_queue_if.slave q
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic branch;
  logic [WIDTH-1:0] branch_addr;
  logic push, pop;
  // While Branch is high the incoming fetch is from the old path and is dropped
  assign push = q.InValid && q.InReady && !q.RedirectValid && !branch;
  assign pop = q.OutValid && q.OutReady && !q.RedirectValid;
  assign q.InReady = count != CW'(DEPTH);
  assign q.OutValid = count != '0;
  assign q.Count = count;
  assign q.Branch = branch;
  assign q.BranchAddress = branch_addr;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      branch <= 1'b0;
      branch_addr <= '0;
    end else if (q.RedirectValid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      branch <= 1'b1;
      branch_addr <= q.RedirectAddress;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
      branch <= 1'b0;
    end
  queue_storage #(.DEPTH(DEPTH), .DW(2*WIDTH), .AW(PW)) u_storage (
    .clk(Clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata({q.Instruction, q.PCAddResult}),
    .raddr(rd_ptr),
    .rdata({q.OutInstruction, q.OutPCAddResult})
  );
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed and random stimulus against a queue-based reference model
module tb_instruction_queue;
  import instruction_queue_pkg::*;
  localparam int D = 4;
  localparam int W = 32;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  entry_t mq[$];
  bit m_br = 1'b0;
  logic [W-1:0] m_ba = '0;
  instruction_queue_if #(.WIDTH(W), .DEPTH(D)) ifc ();
  instruction_queue #(.DEPTH(D), .WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .q(ifc));
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 64'(ifc.Count), 64'(mq.size()));
    chk({tag, "_outvalid"}, 64'(ifc.OutValid), 64'(mq.size() != 0));
    chk({tag, "_inready"}, 64'(ifc.InReady), 64'(mq.size() != D));
    chk({tag, "_branch"}, 64'(ifc.Branch), 64'(m_br));
    chk({tag, "_baddr"}, 64'(ifc.BranchAddress), 64'(m_ba));
    if (mq.size() != 0) begin
      chk({tag, "_head_ins"}, 64'(ifc.OutInstruction), 64'(mq[0].instruction));
      chk({tag, "_head_pc"}, 64'(ifc.OutPCAddResult), 64'(mq[0].pc_add_result));
    end
  endtask

  // Called at a negedge; applies inputs for one rising edge and checks at the next negedge
  task automatic step(input string tag, input logic inv, input logic [W-1:0] ins, input logic [W-1:0] pc,
                      input logic ordy, input logic rv, input logic [W-1:0] ra);
    bit do_push, do_pop;
    ifc.InValid = inv;
    ifc.Instruction = ins;
    ifc.PCAddResult = pc;
    ifc.OutReady = ordy;
    ifc.RedirectValid = rv;
    ifc.RedirectAddress = ra;
    do_pop = mq.size() != 0 && ordy && !rv;
    do_push = inv && mq.size() != D && !m_br && !rv;
    @(posedge Clk);
    if (rv) begin
      mq.delete();
      m_br = 1'b1;
      m_ba = ra;
    end else begin
      m_br = 1'b0;
      if (do_pop) mq.delete(0);
      if (do_push) mq.push_back('{instruction: ins, pc_add_result: pc});
    end
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 Reset = 1'b0;
    #1;
    mq.delete();
    m_br = 1'b0;
    m_ba = '0;
    chk({tag, "_count"}, 64'(ifc.Count), 64'd0);
    chk({tag, "_outvalid"}, 64'(ifc.OutValid), 64'd0);
    chk({tag, "_branch"}, 64'(ifc.Branch), 64'd0);
    chk({tag, "_inready"}, 64'(ifc.InReady), 64'd1);
    chk({tag, "_baddr"}, 64'(ifc.BranchAddress), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] fill_ins [4];
    fill_ins[0] = 32'h20080005;
    fill_ins[1] = 32'h20090007;
    fill_ins[2] = 32'h01095020;
    fill_ins[3] = 32'hAC0A0000;
    ifc.InValid = 1'b0;
    ifc.Instruction = '0;
    ifc.PCAddResult = '0;
    ifc.OutReady = 1'b0;
    ifc.RedirectValid = 1'b0;
    ifc.RedirectAddress = '0;
    repeat (2) @(negedge Clk);
    check_all("reset");
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) step("fill", 1, fill_ins[i], 32'(4 * (i + 1)), 0, 0, 0);
    chk("fill_inready", 64'(ifc.InReady), 64'd0);
    chk("fill_count4", 64'(ifc.Count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(ifc.OutInstruction), 64'(fill_ins[i]));
      step("drain", 0, 0, 0, 1, 0, 0);
    end
    chk("drain_empty", 64'(ifc.Count), 64'd0);
    step("wrap_pre", 1, $urandom, $urandom, 0, 0, 0);
    step("wrap_pre", 1, $urandom, $urandom, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("wrap", 1, $urandom, $urandom, 1, 0, 0);
      chk("wrap_count2", 64'(ifc.Count), 64'd2);
    end
    step("wrap_drain", 0, 0, 0, 1, 0, 0);
    step("wrap_drain", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("refill", 1, $urandom, $urandom, 0, 0, 0);
    step("full_pop", 1, 32'hDEADBEEF, 32'h44, 1, 0, 0);
    chk("full_pop_count3", 64'(ifc.Count), 64'd3);
    chk("full_pop_inready", 64'(ifc.InReady), 64'd1);
    step("flush", 1, $urandom, $urandom, 1, 1, 32'h40);
    chk("flush_branch", 64'(ifc.Branch), 64'd1);
    chk("flush_addr", 64'(ifc.BranchAddress), 64'h40);
    step("squash", 1, $urandom, $urandom, 0, 0, 0);
    chk("squash_count0", 64'(ifc.Count), 64'd0);
    chk("squash_branch0", 64'(ifc.Branch), 64'd0);
    step("redir1", 0, 0, 0, 0, 1, 32'h40);
    step("redir2", 0, 0, 0, 0, 1, 32'h80);
    chk("redir2_branch", 64'(ifc.Branch), 64'd1);
    chk("redir2_addr", 64'(ifc.BranchAddress), 64'h80);
    step("redir_end", 0, 0, 0, 0, 0, 0);
    chk("hold_addr", 64'(ifc.BranchAddress), 64'h80);
    step("pre_rst", 1, $urandom, $urandom, 0, 0, 0);
    step("pre_rst", 1, $urandom, $urandom, 0, 0, 0);
    async_reset("rst_count2");
    step("first_push", 1, 32'h1234_5678, 32'h4, 0, 0, 0);
    chk("first_push_count", 64'(ifc.Count), 64'd1);
    step("pre_rst_br", 0, 0, 0, 0, 1, 32'h100);
    async_reset("rst_branch");
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
